addsub_accum_pipe: RTL
======================

Name: addsub_accum_pipe

Overview:
Parametrised, two-stage pipelined signed/unsigned adder–subtractor with a built-in accumulator mode, optional signed saturation and sticky overflow. It is the next-generation replacement for the fixed-function synchronous add/sub block. It sits between switch/operand registers and the hex display path, and it also serves the upcoming multiply-accumulate labs.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2)
SAT_DEFAULT, 0, value of the saturation enable when sat_en is tied off by the instantiating module

Ports:
clk  in  1  single system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand strobe; operands and mode are sampled when high
mode  in  2  00 A+B, 01 A-B, 10 ACC+=A, 11 ACC-=A
a  in  WIDTH  operand A (two's complement for overflow/saturation purposes)
b  in  WIDTH  operand B (ignored in accumulate modes)
sat_en  in  1  1 = clamp result on signed overflow
clr  in  1  synchronous flush: zero accumulator, clear sticky flag, kill pipeline
result  out  WIDTH  registered result
out_valid  out  1  high for exactly one cycle per accepted operation
cout  out  1  raw carry out of the WIDTH-bit adder (for subtract: 1 = no borrow)
ovf  out  1  signed overflow of this operation (before saturation)
zero  out  1  result == 0
ovf_sticky  out  1  OR of all ovf since last reset/clr
acc  out  WIDTH  current accumulator contents

Behaviour:
- Reset (synchronous, active-high, highest priority): result, acc, cout, ovf, zero, ovf_sticky, out_valid and all stage-1 registers go to 0.
- Stage 1 (edge N): if in_valid, register a, b, mode, sat_en, and set s1_valid = 1; otherwise s1_valid = 0.
- Stage 2 (edge N+1): if s1_valid, compute and register outputs; out_valid = 1. Latency is therefore 2 cycles from in_valid to out_valid.
- Throughput: one operation per cycle, no stalls, no backpressure.
- Operand selection: modes 00/01 use left=a, right=b. Modes 10/11 use left=acc (the register value at that edge), right=a.
- Arithmetic: sum = left + (sub ? ~right : right) + sub, computed at WIDTH+1 bits. cout is bit WIDTH of that sum.
- Signed overflow:
  - add: left[MSB] == right[MSB] and sum[MSB] != left[MSB].
  - sub: left[MSB] != right[MSB] and sum[MSB] != left[MSB].
- Saturation: if sat_en and ovf, result = 0111…1 when left[MSB] == 0, else 1000…0. Otherwise result = sum[WIDTH-1:0].
- Accumulate modes: acc <= final result (saturated if applicable). Modes 00/01 leave acc unchanged.
- Back-to-back accumulates: each consecutive one sees the previous update, with no hazard.
- Flags: zero evaluates the final result. ovf_sticky <= ovf_sticky | ovf on every completed operation.
- When no operation completes: out_valid = 0; result, cout, ovf and zero hold their last values.
- clr (priority below reset, above everything else): at the edge, acc = 0, ovf_sticky = 0, s1_valid = 0, out_valid = 0.
  - An in_valid asserted in the clr cycle is dropped.
  - An operation in stage 1 at the clr edge is discarded.
  - result, cout, ovf and zero hold their last values.
- Reset asserted mid-stream: both in-flight operations are lost; the first in_valid after reset deasserts produces out_valid 2 cycles later.
- Wrap-around: with sat_en = 0, overflow wraps modulo 2^WIDTH; ovf and ovf_sticky still assert.

Decomposition:
- Shared package holds the mode encoding constants (MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC_ADD=2'b10, MODE_ACC_SUB=2'b11) and the saturation-limit helper functions (max_pos(WIDTH), min_neg(WIDTH)).
- One sub-module: addsub_core. It is combinational, WIDTH-parametrised, and produces sum, cout and ovf from left, right and sub. The pipeline registers, accumulator, saturation mux and flags stay in the top module.

Test Plan:
- Add, WIDTH=8: in_valid with mode=00, a=0x11, b=0x05 -> 2 cycles later out_valid=1, result=0x16, cout=0, ovf=0, zero=0.
- Subtract with borrow and wrap: mode=01, a=0x05, b=0x11, sat_en=0 -> result=0xF4, cout=0, ovf=0. Then mode=01, a=0x80, b=0x01 -> result=0x7F, ovf=1, ovf_sticky=1.
- Saturation: sat_en=1, mode=00, a=0x7F, b=0x01 -> result=0x7F, ovf=1. Then mode=01, a=0x80, b=0x01 -> result=0x80, ovf=1.
- Back-to-back accumulate: clr, then mode=10 with a=0x10, 0x20, 0x30 on consecutive cycles -> results 0x10, 0x20… exactly: 0x10, 0x30, 0x60 on consecutive out_valid cycles; acc=0x60. Then mode=11, a=0x60 -> result=0x00, zero=1.
- Flush: with ops in flight, assert clr together with in_valid -> out_valid stays 0 for the next 2 cycles, acc=0, ovf_sticky=0, result unchanged.
- Reset mid-stream: assert reset during a back-to-back accumulate burst -> every output is 0 on the next cycle. After release, mode=10, a=0x01 -> result=0x01 two cycles later.

Source files
------------

// File: rtl/addsub_accum_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_accum_pipe_pkg
// Description : Shared definitions for the pipelined add/sub accumulator.
//               Holds the operation mode encoding and the helpers that
//               produce the signed saturation limits for a given width.
// Revision    : 1.0  initial release
// ============================================================================
package addsub_accum_pipe_pkg;

    // Operation mode encoding (mode[1] = accumulate, mode[0] = subtract)
    localparam logic [1:0] MODE_ADD     = 2'b00;
    localparam logic [1:0] MODE_SUB     = 2'b01;
    localparam logic [1:0] MODE_ACC_ADD = 2'b10;
    localparam logic [1:0] MODE_ACC_SUB = 2'b11;

    // Widest operand the limit helpers can describe.
    localparam int LIMIT_W = 64;

    // Largest positive two's complement value of 'width' bits: 0111...1
    function automatic logic [LIMIT_W-1:0] max_pos(input int width);
        max_pos = (LIMIT_W'(1) << (width - 1)) - LIMIT_W'(1);
    endfunction

    // Most negative two's complement value of 'width' bits: 1000...0
    function automatic logic [LIMIT_W-1:0] min_neg(input int width);
        min_neg = LIMIT_W'(1) << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_accum_pipe_core.sv
`default_nettype none
// ============================================================================
// Module      : addsub_core
// Description : Combinational WIDTH-bit adder/subtractor with raw carry out
//               and two's complement overflow detection.
// Ports       : left, right  operands (result = left +/- right)
//               sub          1 = subtract (left + ~right + 1)
//               sum          low WIDTH bits of the result
//               cout         bit WIDTH of the extended sum (sub: 1 = no borrow)
//               ovf          signed overflow of this operation
// Revision    : 1.0  initial release
// ============================================================================
module addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_rhs;
    logic [WIDTH:0]   w_full;
    logic             w_l_msb;
    logic             w_r_msb;
    logic             w_s_msb;

    assign w_rhs   = sub ? ~right : right;
    assign w_full  = {1'b0, left} + {1'b0, w_rhs} + {{WIDTH{1'b0}}, sub};
    assign sum     = w_full[WIDTH-1:0];
    assign cout    = w_full[WIDTH];

    assign w_l_msb = left[WIDTH-1];
    assign w_r_msb = right[WIDTH-1];
    assign w_s_msb = w_full[WIDTH-1];

    // Overflow when the operands effectively share a sign and the result
    // sign differs from it; subtracting flips the sign of the right operand.
    always_comb begin
        ovf = 1'b0;
        if (sub) begin
            ovf = (w_l_msb != w_r_msb) && (w_s_msb != w_l_msb);
        end else begin
            ovf = (w_l_msb == w_r_msb) && (w_s_msb != w_l_msb);
        end
    end

endmodule
`default_nettype wire

// File: rtl/addsub_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_accum_pipe
// Description : Two-stage pipelined signed/unsigned adder-subtractor with an
//               accumulator mode, optional signed saturation and a sticky
//               overflow flag. One operation per cycle, latency 2.
// Ports       : clk, reset   clock, synchronous active-high reset
//               in_valid     operand strobe (mode/a/b/sat_en sampled)
//               mode         00 A+B, 01 A-B, 10 ACC+=A, 11 ACC-=A
//               a, b         operands (b ignored in accumulate modes)
//               sat_en       clamp result on signed overflow
//               clr          flush: zero acc, clear sticky, kill pipeline
//               result       registered result
//               out_valid    one-cycle strobe per completed operation
//               cout, ovf    carry out / signed overflow of last operation
//               zero         last result == 0
//               ovf_sticky   OR of ovf since last reset/clr
//               acc          accumulator contents
// Parameters  : WIDTH        operand width (>= 2)
//               SAT_DEFAULT  value the instantiating module should tie sat_en
//                            to when it has no dynamic saturation control
// Revision    : 1.0  initial release
// ============================================================================
module addsub_accum_pipe
    import addsub_accum_pipe_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SAT_DEFAULT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    input  logic             clr,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] acc
);

    generate
        if (WIDTH < 2 || WIDTH > LIMIT_W ||
            (SAT_DEFAULT != 0 && SAT_DEFAULT != 1)) begin : g_bad_param
            $error("addsub_accum_pipe: illegal WIDTH or SAT_DEFAULT");
        end
    endgenerate

    localparam logic [LIMIT_W-1:0] c_max_full = max_pos(WIDTH);
    localparam logic [LIMIT_W-1:0] c_min_full = min_neg(WIDTH);
    localparam logic [WIDTH-1:0]   c_max_pos  = c_max_full[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   c_min_neg  = c_min_full[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [1:0]       r_s1_mode;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sat   <= 1'b0;
        end else if (clr) begin
            // An operand strobe coinciding with clr is dropped.
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= mode;
                r_s1_a    <= a;
                r_s1_b    <= b;
                r_s1_sat  <= sat_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: operand selection, arithmetic, saturation
    // ------------------------------------------------------------------
    logic             w_acc_mode;
    logic             w_sub;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_acc_mode = 1'b0;
        w_sub      = 1'b0;
        unique case (r_s1_mode)
            MODE_ADD:     begin w_acc_mode = 1'b0; w_sub = 1'b0; end
            MODE_SUB:     begin w_acc_mode = 1'b0; w_sub = 1'b1; end
            MODE_ACC_ADD: begin w_acc_mode = 1'b1; w_sub = 1'b0; end
            MODE_ACC_SUB: begin w_acc_mode = 1'b1; w_sub = 1'b1; end
            default:      begin w_acc_mode = 1'b0; w_sub = 1'b0; end
        endcase
    end

    // The accumulator register is read directly; since it updates on the
    // same edge that completes an accumulate, the next op already sees it.
    assign w_left  = w_acc_mode ? acc    : r_s1_a;
    assign w_right = w_acc_mode ? r_s1_a : r_s1_b;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .left  (w_left),
        .right (w_right),
        .sub   (w_sub),
        .sum   (w_sum),
        .cout  (w_cout),
        .ovf   (w_ovf)
    );

    // Clamp direction follows the sign of the left operand: an overflowing
    // result always lies beyond the limit on that side.
    always_comb begin
        w_result = w_sum;
        if (r_s1_sat && w_ovf) begin
            w_result = w_left[WIDTH-1] ? c_min_neg : c_max_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result     <= '0;
            out_valid  <= 1'b0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            ovf_sticky <= 1'b0;
            acc        <= '0;
        end else if (clr) begin
            // result/cout/ovf/zero keep their last values across a flush.
            out_valid  <= 1'b0;
            ovf_sticky <= 1'b0;
            acc        <= '0;
        end else if (r_s1_valid) begin
            result     <= w_result;
            out_valid  <= 1'b1;
            cout       <= w_cout;
            ovf        <= w_ovf;
            zero       <= (w_result == '0);
            ovf_sticky <= ovf_sticky | w_ovf;
            if (w_acc_mode) begin
                acc <= w_result;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
